// File: rtl/mac4_seq_accum.sv
// ============================================================================
// Module      : mac4_seq_accum
// Description : 4x4 unsigned shift-add multiplier feeding an 8-bit accumulator
//               with a sticky carry-out flag. Define MAC4_SATURATE_EN to make
//               the accumulator saturate at 8'hFF instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac4_seq_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       clr_acc,
    output logic [7:0] acc,
    output logic       acc_valid,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    localparam logic [1:0] c_LAST_STEP = 2'd3;

    state_t      r_state;
    logic [7:0]  r_mcand;
    logic [3:0]  r_mplier;
    logic [7:0]  r_pp;
    logic [1:0]  r_cnt;
    logic [7:0]  r_acc;
    logic        r_acc_valid;
    logic        r_ovf;

    logic [8:0]  w_sum;
    logic        w_carry;
    logic [7:0]  w_acc_next;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_pp};
    assign w_carry = w_sum[8];

`ifdef MAC4_SATURATE_EN
    assign w_acc_next = w_carry ? 8'hFF : w_sum[7:0];
`else
    assign w_acc_next = w_sum[7:0];
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign acc       = r_acc;
    assign acc_valid = r_acc_valid;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= 8'h00;
            r_mplier    <= 4'h0;
            r_pp        <= 8'h00;
            r_cnt       <= 2'd0;
            r_acc       <= 8'h00;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;

            // A clear outside ACC leaves the operation in flight untouched;
            // the ACC branch below overrides this to load the fresh product.
            if (clr_acc) begin
                r_acc <= 8'h00;
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {4'h0, in_a};
                        r_mplier <= in_b;
                        r_pp     <= 8'h00;
                        r_cnt    <= 2'd0;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_pp <= r_pp + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 2'd1;
                    if (r_cnt == c_LAST_STEP) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc_valid <= 1'b1;
                    r_state     <= S_IDLE;
                    if (clr_acc) begin
                        r_acc <= r_pp;
                    end else begin
                        r_acc <= w_acc_next;
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac4_seq_accum.sv
// ============================================================================
// Module      : tb_mac4_seq_accum
// Description : Directed, table-driven self-checking bench for mac4_seq_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac4_seq_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       clr_acc;
    logic [7:0] acc;
    logic       acc_valid;
    logic       ovf;
    logic       busy;

    int n_checks;
    int n_fail;

    mac4_seq_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .clr_acc   (clr_acc),
        .acc       (acc),
        .acc_valid (acc_valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         clr_n;     // negedge index (after handshake) to pulse clr_acc; 0 = none
        logic [7:0] exp_acc;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation: handshake, scramble inputs, track latency/in_ready, check result.
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        int ready_bad;
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", idx), {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        lat       = -1;
        ready_bad = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a     = ~v.a;
            in_b     = ~v.b;
            clr_acc  = 1'b0;
            if (n <= 5 && in_ready) ready_bad++;
            if (acc_valid) begin
                lat = n;
                break;
            end
            if (n == v.clr_n) clr_acc = 1'b1;
        end
        clr_acc = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, 6);
        chk($sformatf("v%0d_ready_low", idx), ready_bad, 0);
        chk($sformatf("v%0d_acc", idx), {24'd0, acc}, {24'd0, v.exp_acc});
        chk($sformatf("v%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.exp_ovf});
        @(negedge clk);
        chk($sformatf("v%0d_valid_pulse", idx), {31'd0, acc_valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        int low_cycles;
        int stray;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = 4'h0;
        in_b     = 4'h0;
        clr_acc  = 1'b0;

        vecs[0]  = '{4'd3,  4'd5,  0, 8'h0F, 1'b0};
        vecs[1]  = '{4'd0,  4'd9,  0, 8'h0F, 1'b0};
        vecs[2]  = '{4'd15, 4'd0,  0, 8'h0F, 1'b0};
        vecs[3]  = '{4'd15, 4'd15, 2, 8'hE1, 1'b0};
`ifdef MAC4_SATURATE_EN
        vecs[4]  = '{4'd15, 4'd15, 0, 8'hFF, 1'b1};
        vecs[5]  = '{4'd1,  4'd1,  0, 8'hFF, 1'b1};
`else
        vecs[4]  = '{4'd15, 4'd15, 0, 8'hC2, 1'b1};
        vecs[5]  = '{4'd1,  4'd1,  0, 8'hC3, 1'b1};
`endif
        vecs[6]  = '{4'd8,  4'd8,  2, 8'h40, 1'b0};
        vecs[7]  = '{4'd7,  4'd9,  5, 8'h3F, 1'b0};
        vecs[8]  = '{4'd12, 4'd10, 0, 8'hB7, 1'b0};
`ifdef MAC4_SATURATE_EN
        vecs[9]  = '{4'd13, 4'd11, 0, 8'hFF, 1'b1};
`else
        vecs[9]  = '{4'd13, 4'd11, 0, 8'h46, 1'b1};
`endif
        vecs[10] = '{4'd2,  4'd3,  5, 8'h06, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_acc",       {24'd0, acc},       32'h00);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        for (int i = 0; i < 11; i++) run_op(vecs[i], i);

        // Reset mid-operation: acc=0x10 first, then 6x6 aborted at edge T+2.
        run_op('{4'd4, 4'd4, 2, 8'h10, 1'b0}, 11);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 4'd6;
        in_b     = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_acc",      {24'd0, acc},      32'h00);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy",     {31'd0, busy},     32'd0);
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            if (acc_valid) stray++;
            @(negedge clk);
        end
        chk("abort_no_valid", stray, 0);
        chk("abort_acc_hold", {24'd0, acc}, 32'h00);

        // in_valid held high: exactly three 2x2 operations, then dropped.
        pulses     = 0;
        low_cycles = 0;
        in_valid   = 1'b1;
        in_a       = 4'd2;
        in_b       = 4'd2;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (acc_valid) pulses++;
            if (!in_ready) low_cycles++;
            if (k == 18) in_valid = 1'b0;
        end
        chk("hold_pulses",     pulses,      3);
        chk("hold_ready_low",  low_cycles,  15);
        chk("hold_final_acc",  {24'd0, acc}, 32'h0C);
        chk("hold_final_ovf",  {31'd0, ovf}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac4_seq_accum.md
MAC4_SEQ_ACCUM -- requirements
Module: mac4_seq_accum

Interface
REQ-001 SHALL have one clock `clk` and a synchronous, active-high reset `rst`.
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  4  unsigned multiplicand.
- in_b  in  4  unsigned multiplier.
- clr_acc  in  1  synchronous clear of accumulator and overflow flag.
- acc  out  8  accumulator value, registered.
- acc_valid  out  1  one-cycle pulse when acc is updated by an operation.
- ovf  out  1  sticky accumulation overflow flag.
- busy  out  1  operation in progress, i.e. state is not IDLE.

Function
REQ-003 SHALL treat all arithmetic as unsigned; the product is 8 bits, the accumulator is 8 bits, and the adder carry-out is the overflow indication.
REQ-004 SHALL implement the FSM states IDLE, MUL and ACC:
- IDLE -> MUL on `in_valid & in_ready`.
- MUL -> ACC after exactly 4 cycles.
- ACC -> IDLE after 1 cycle.
REQ-005 SHALL assert in_ready only in IDLE, combinationally from state; no other state accepts operands.
REQ-006 SHALL capture in_a and in_b on the handshake edge T; later input changes SHALL NOT affect the operation.
REQ-007 SHALL compute the product by shift-add over the MUL edges T+1..T+4, one multiplier bit per edge, LSB first, using a 8-bit partial-product register.
REQ-008 SHALL write `acc <= acc + product` on edge T+5 and assert acc_valid for exactly the cycle following T+5.
REQ-009 SHALL therefore have a latency of 6 cycles from handshake to acc_valid, with a next acceptance no earlier than edge T+6.
REQ-010 SHALL set ovf when the ACC-edge addition produces a carry-out; once set, ovf SHALL remain set until clr_acc or rst.
REQ-011 SHALL, on clr_acc in IDLE or MUL, clear acc and ovf on that edge without disturbing the FSM or the operation in flight.
REQ-012 SHALL, when clr_acc coincides with the ACC edge, write `acc <= product`, leave ovf at 0, and still pulse acc_valid.
REQ-013 SHALL ignore in_valid while busy; holding in_valid high produces exactly one acceptance per IDLE visit.
REQ-014 SHALL produce a correct accumulation for a zero product, including any operand equal to 0.

Reset
REQ-015 SHALL, while rst is high on a clock edge, force:
- state to IDLE;
- acc = 8'h00;
- ovf = 0;
- acc_valid = 0;
- busy = 0;
- in_ready = 1 from the following cycle;
- internal operand and partial-product registers cleared.
REQ-016 SHALL abort any in-flight operation on reset mid-operation, with no acc write and no acc_valid pulse; rst SHALL have priority over clr_acc and the handshake.

Configuration
REQ-017 SHALL support the macro MAC4_SATURATE_EN:
- Defined: on carry-out, acc SHALL saturate to 8'hFF and ovf SHALL be set.
- Undefined: acc SHALL wrap modulo 256 and ovf SHALL be set.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-018 After reset, 3x5 -> acc=8'h0F, acc_valid pulses 6 cycles after the handshake, ovf=0.
REQ-019 15x15 twice, without MAC4_SATURATE_EN -> acc=8'hE1, then acc=8'hC2 with ovf=1.
REQ-020 With MAC4_SATURATE_EN, 15x15 twice -> acc=8'hE1, then acc=8'hFF with ovf=1.
REQ-021 acc=8'h40, then 7x9 with clr_acc pulsed on the ACC edge -> acc=8'h3F, ovf=0, acc_valid=1.
REQ-022 rst asserted on edge T+2 of 6x6 with acc=8'h10 -> acc=8'h00, no acc_valid pulse, in_ready=1 one cycle after the reset edge.
REQ-023 in_valid held high across three operations (2x2 each) -> in_ready low for cycles T+1..T+5 of each; exactly three acc_valid pulses; final acc=8'h0C.
